ikbd_serial_link: RTL and testbench
===================================

// Module: ikbd_serial_link
// PURPOSE
//  Host-side serial link controller for the IKBD MCU SCI. Buffers host bytes in a
//  TX FIFO and serialises them as 8N1 frames onto the MCU serial input (P22 / rx).
//  Deserialises MCU serial output (txd) into bytes for the host.
//  Bit timing runs on the same clock-enable that paces the MCU core, so the SCI
//  rate (256 enable ticks per bit) is matched exactly.
// PARAMETERS
//  BIT_CYCLES  256  clken ticks per serial bit; even, >=4
//  FIFO_DEPTH  4    TX FIFO entries; power of 2, >=2
// PORTS
//  mcu_clx2   in   1  system clock (only clock)
//  mcu_rst_n  in   1  reset, asynchronous, active-low
//  clken      in   1  bit-timing enable; FSMs and bit counters advance only when high
//  tx_data    in   8  host byte to send to the MCU
//  tx_valid   in   1  tx_data valid
//  tx_ready   out  1  FIFO can accept; push = tx_valid & tx_ready at clock edge
//  tx_busy    out  1  FIFO non-empty or TX frame in progress
//  sci_rxd    out  1  serial line to MCU SCI rx; idle high
//  sci_txd    in   1  serial line from MCU SCI tx; idle high
//  rx_data    out  8  last received byte; held until next frame completes
//  rx_valid   out  1  one-cycle pulse: rx_data updated
//  rx_ferr    out  1  one-cycle pulse, coincident with rx_valid: stop bit sampled 0
// BEHAVIOUR
//  Reset: sci_rxd=1, tx_ready=1, tx_busy=0, rx_data=8'h00, rx_valid=0, rx_ferr=0.
//   FIFO emptied; both FSMs in idle state; bit counters = 0.
//  FIFO:
//   - Push on any clock edge, independent of clken.
//   - tx_ready = !full, decoded from registered count.
//   - Full + pop in same cycle: push is still refused (no bypass).
//   - Empty: no pop occurs.
//  TX FSM (T_IDLE, T_START, T_DATA, T_STOP); bit counter 0..BIT_CYCLES-1 on clken:
//   - T_IDLE & clken & FIFO non-empty: pop; sci_rxd<=0; cnt<=0 -> T_START.
//   - Each bit holds for BIT_CYCLES clken ticks.
//   - T_DATA: 8 bits, LSB first.
//   - T_STOP: drive 1 for BIT_CYCLES ticks. On the last tick, if FIFO is non-empty,
//     pop and enter T_START directly (no idle gap); else -> T_IDLE.
//   - Frame = 10*BIT_CYCLES clken ticks. sci_rxd is a register output (glitch-free).
//  RX FSM (R_IDLE, R_START, R_DATA, R_STOP):
//   - sci_txd passes a 2-flop synchroniser (2-cycle latency); edge detection uses
//     the synchronised value and its previous value, sampled on clken ticks.
//   - R_IDLE: on a clken tick where prev=1 and cur=0: cnt<=0 -> R_START.
//   - R_START: at cnt==BIT_CYCLES/2-1 (bit centre): line 0 -> R_DATA, cnt<=0;
//     line 1 -> glitch, return to R_IDLE, no output.
//   - R_DATA: sample at cnt==BIT_CYCLES-1; shift in LSB first; after 8 bits -> R_STOP.
//   - R_STOP: sample at cnt==BIT_CYCLES-1. Load rx_data, pulse rx_valid, and pulse
//     rx_ferr if the sample is 0; then -> R_IDLE.
//   - After a framing error, a new start needs a fresh 1->0 edge (line must go high).
//   - Host has no back-pressure: a byte not taken is overwritten by the next frame.
//  clken low: counters, FSMs and sci_rxd hold; synchroniser still clocks.
//  Reset mid-frame: sci_rxd returns to 1 immediately; partial frames are discarded.
// STRUCTURE
//  - Shared include ikbd_defs.vh: TX/RX state encodings, FRAME_BITS=10, DATA_BITS=8.
//  - One sub-module ikbd_byte_fifo: 8-bit sync FIFO, async active-low reset,
//    push/pop/full/empty, count-based.
//  - TX FSM, RX FSM and synchroniser stay in this module.
// TESTING (BIT_CYCLES=16, FIFO_DEPTH=4, clken=1 unless stated)
//  1. Push 8'hA5 -> sci_rxd: 0 for 16 cycles, then bits 1,0,1,0,0,1,0,1
//     (16 cycles each), then 1 for 16 cycles; tx_busy falls after 160 cycles.
//  2. Push 5 bytes back-to-back while idle -> 5th accepted only after first pop;
//     tx_ready low while count==4; frames contiguous, 800 cycles, no idle gap.
//  3. Drive sci_txd with an 8'h3C frame -> one rx_valid pulse, rx_data=8'h3C,
//     rx_ferr=0, ~2+10*16-8 cycles after the start edge.
//  4. sci_txd low for 4 cycles then high -> no rx_valid. Frame 8'h55 with stop bit 0
//     -> rx_valid=1, rx_ferr=1, rx_data=8'h55; then no restart until line high.
//  5. clken=1 every 3rd cycle -> frame of 8'h81 spans 480 clocks; loopback
//     (sci_rxd->sci_txd) returns 8'h81.
//  6. Assert mcu_rst_n low mid-data-bit with 3 bytes queued -> sci_rxd=1 at once,
//     tx_ready=1, tx_busy=0; after release, nothing is sent.

Source files
------------

// File: rtl/ikbd_serial_link_pkg.sv
// Shared definitions for the IKBD host-side serial link: frame geometry and
// the state encodings of the TX and RX frame FSMs.
package ikbd_serial_link_pkg;

  // 8N1 frame: one start bit, eight data bits, one stop bit.
  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

  typedef enum logic [1:0] {
    T_IDLE  = 2'd0,
    T_START = 2'd1,
    T_DATA  = 2'd2,
    T_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_DATA  = 2'd2,
    R_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/ikbd_byte_fifo.sv
// Small count-based synchronous byte FIFO. A push while full and a pop while
// empty are ignored; full/empty are decoded from the registered count, so a
// pop in the same cycle does not make room for a push (no bypass).
module ikbd_byte_fifo
  import ikbd_serial_link_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic [DATA_BITS-1:0] data_i,
  input  logic                 pop_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          count_q;
  logic                 do_push, do_pop;

  assign full_o  = (count_q == (AW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // Storage array: written on an accepted push, no reset needed.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers wrap naturally (power-of-two depth); count tracks occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ikbd_serial_link.sv
// Host-side serial link to the IKBD MCU SCI. Host bytes are queued in a small
// FIFO and sent as 8N1 frames on sci_rxd; frames arriving on sci_txd are
// deserialised into rx_data. All bit timing advances on clken only, so the
// link runs at exactly BIT_CYCLES enable ticks per bit, like the MCU's SCI.
//
// Host TX handshake: a byte is taken on any clock edge where tx_valid and
// tx_ready are both high; tx_ready depends only on registered FIFO state.
// Host RX has no back-pressure: rx_valid is a one-cycle strobe and rx_data
// is simply overwritten by the next completed frame.
module ikbd_serial_link
  import ikbd_serial_link_pkg::*;
#(
  parameter int BIT_CYCLES = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       mcu_clx2,
  input  logic       mcu_rst_n,
  input  logic       clken,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       sci_rxd,
  input  logic       sci_txd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ferr,
  output logic [1:0] dbg_tx_state,
  output logic [1:0] dbg_rx_state
);

  localparam int             CW       = $clog2(BIT_CYCLES);
  localparam int             DBITS    = FRAME_BITS - 2;
  localparam logic [CW-1:0]  CNT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_MID  = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [2:0]     BIT_LAST = 3'(DBITS - 1);

  // ---------------------------------------------------------------- FIFO
  logic                 fifo_pop, fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;

  ikbd_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (mcu_clx2),
    .rst_ni  (mcu_rst_n),
    .push_i  (tx_valid),
    .data_i  (tx_data),
    .pop_i   (fifo_pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign tx_ready = ~fifo_full;

  // ---------------------------------------------------------------- TX
  tx_state_e            tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shreg_q, tx_shreg_d;
  logic                 rxd_q, rxd_d;

  assign sci_rxd      = rxd_q;
  assign tx_busy      = ~fifo_empty | (tx_state_q != T_IDLE);
  assign dbg_tx_state = tx_state_q;

  // TX next state: line value is decided one tick ahead so sci_rxd is a flop.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shreg_d = tx_shreg_q;
    rxd_d      = rxd_q;
    fifo_pop   = 1'b0;
    if (clken) begin
      case (tx_state_q)
        T_IDLE: begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            tx_shreg_d = fifo_rdata;
            rxd_d      = 1'b0;
            tx_cnt_d   = '0;
            tx_state_d = T_START;
          end
        end
        T_START: begin
          if (tx_cnt_q == CNT_LAST) begin
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
            rxd_d      = tx_shreg_q[0];
            tx_state_d = T_DATA;
          end else begin
            tx_cnt_d = tx_cnt_q + CW'(1);
          end
        end
        T_DATA: begin
          if (tx_cnt_q == CNT_LAST) begin
            tx_cnt_d = '0;
            if (tx_bit_q == BIT_LAST) begin
              rxd_d      = 1'b1;
              tx_state_d = T_STOP;
            end else begin
              tx_bit_d   = tx_bit_q + 3'd1;
              tx_shreg_d = {1'b0, tx_shreg_q[DATA_BITS-1:1]};
              rxd_d      = tx_shreg_q[1];
            end
          end else begin
            tx_cnt_d = tx_cnt_q + CW'(1);
          end
        end
        T_STOP: begin
          if (tx_cnt_q == CNT_LAST) begin
            tx_cnt_d = '0;
            // Back-to-back frames: go straight to the next start bit.
            if (!fifo_empty) begin
              fifo_pop   = 1'b1;
              tx_shreg_d = fifo_rdata;
              rxd_d      = 1'b0;
              tx_state_d = T_START;
            end else begin
              tx_state_d = T_IDLE;
            end
          end else begin
            tx_cnt_d = tx_cnt_q + CW'(1);
          end
        end
        default: tx_state_d = T_IDLE;
      endcase
    end
  end

  // TX state register; reset forces the line idle-high immediately.
  always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
    if (!mcu_rst_n) begin
      tx_state_q <= T_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shreg_q <= '0;
      rxd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shreg_q <= tx_shreg_d;
      rxd_q      <= rxd_d;
    end
  end

  // ---------------------------------------------------------------- RX
  logic                 sync1_q, sync2_q;
  logic                 rx_prev_q, rx_prev_d;
  rx_state_e            rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shreg_q, rx_shreg_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_ferr_q, rx_ferr_d;

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_ferr      = rx_ferr_q;
  assign dbg_rx_state = rx_state_q;

  // Two-flop synchroniser on the asynchronous MCU line; runs every clock.
  always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
    if (!mcu_rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= sci_txd;
      sync2_q <= sync1_q;
    end
  end

  // RX next state: start edge found on ticks, bits sampled near their centre.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shreg_d = rx_shreg_q;
    rx_data_d  = rx_data_q;
    rx_prev_d  = rx_prev_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    if (clken) begin
      rx_prev_d = sync2_q;
      case (rx_state_q)
        R_IDLE: begin
          // A low line alone is not enough: a framing error must see the
          // line return high before the next start is accepted.
          if (rx_prev_q && !sync2_q) begin
            rx_cnt_d   = '0;
            rx_state_d = R_START;
          end
        end
        R_START: begin
          if (rx_cnt_q == CNT_MID) begin
            rx_cnt_d = '0;
            rx_bit_d = '0;
            rx_state_d = sync2_q ? R_IDLE : R_DATA;
          end else begin
            rx_cnt_d = rx_cnt_q + CW'(1);
          end
        end
        R_DATA: begin
          if (rx_cnt_q == CNT_LAST) begin
            rx_cnt_d   = '0;
            rx_shreg_d = {sync2_q, rx_shreg_q[DATA_BITS-1:1]};
            if (rx_bit_q == BIT_LAST) begin
              rx_state_d = R_STOP;
            end else begin
              rx_bit_d = rx_bit_q + 3'd1;
            end
          end else begin
            rx_cnt_d = rx_cnt_q + CW'(1);
          end
        end
        R_STOP: begin
          if (rx_cnt_q == CNT_LAST) begin
            rx_cnt_d   = '0;
            rx_data_d  = rx_shreg_q;
            rx_valid_d = 1'b1;
            rx_ferr_d  = ~sync2_q;
            rx_state_d = R_IDLE;
          end else begin
            rx_cnt_d = rx_cnt_q + CW'(1);
          end
        end
        default: rx_state_d = R_IDLE;
      endcase
    end
  end

  // RX state register and host-facing outputs.
  always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
    if (!mcu_rst_n) begin
      rx_state_q <= R_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shreg_q <= '0;
      rx_data_q  <= '0;
      rx_prev_q  <= 1'b1;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shreg_q <= rx_shreg_d;
      rx_data_q  <= rx_data_d;
      rx_prev_q  <= rx_prev_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

endmodule

// File: tb/tb_ikbd_serial_link.sv
// Bench for ikbd_serial_link with BIT_CYCLES=16, FIFO_DEPTH=4.
module tb_ikbd_serial_link;

  localparam int BC = 16;

  logic       mcu_clx2 = 1'b0;
  logic       mcu_rst_n;
  logic       clken;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx_busy, sci_rxd;
  logic       sci_txd_drv, loop_en;
  logic       sci_txd;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ferr;
  logic [1:0] dbg_tx_state, dbg_rx_state;

  assign sci_txd = loop_en ? sci_rxd : sci_txd_drv;

  ikbd_serial_link #(.BIT_CYCLES(BC), .FIFO_DEPTH(4)) dut (
    .mcu_clx2     (mcu_clx2),
    .mcu_rst_n    (mcu_rst_n),
    .clken        (clken),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_busy      (tx_busy),
    .sci_rxd      (sci_rxd),
    .sci_txd      (sci_txd),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ferr      (rx_ferr),
    .dbg_tx_state (dbg_tx_state),
    .dbg_rx_state (dbg_rx_state)
  );

  // ---------------------------------------------------------- clock / reset
  always #5 mcu_clx2 = ~mcu_clx2;

  int cyc = 0;
  always @(posedge mcu_clx2) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------- scoreboard
  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  int         got_cyc = 0;
  int         stray_ferr = 0;
  int         t0 = 0;

  always @(negedge mcu_clx2) begin
    if (rx_valid) begin
      got_q.push_back({rx_ferr, rx_data});
      got_cyc = cyc;
    end
    if (rx_ferr && !rx_valid) stray_ferr++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_rx(input string name);
    chk({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({name, "_word"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------------------------------------------------- drivers
  task automatic push_byte(input logic [7:0] d);
    bit ok;
    ok = 0;
    @(negedge mcu_clx2);
    tx_data  = d;
    tx_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (tx_ready) begin
        ok = 1;
        break;
      end
      @(negedge mcu_clx2);
    end
    if (!ok) chk("push_timeout", 0, 1);
    @(negedge mcu_clx2);
    tx_valid = 1'b0;
  endtask

  task automatic wait_fall(output bit ok);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge mcu_clx2);
      if (!sci_rxd) begin
        ok = 1;
        return;
      end
    end
  endtask

  // Starts on the negedge where the start bit is first visible; ends on the
  // negedge holding the last stop-bit cycle.
  task automatic check_frame(input logic [9:0] f, input string name);
    logic seen;
    for (int b = 0; b < 10; b++) begin
      seen = f[b];
      for (int c = 0; c < BC; c++) begin
        if (!(b == 0 && c == 0)) @(negedge mcu_clx2);
        if (sci_rxd !== f[b]) seen = sci_rxd;
      end
      chk($sformatf("%s_bit%0d", name, b), seen, f[b]);
    end
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stopv);
    logic [9:0] f;
    f = {stopv, d, 1'b0};
    @(negedge mcu_clx2);
    t0 = cyc;
    for (int b = 0; b < 10; b++) begin
      sci_txd_drv = f[b];
      repeat (BC) @(negedge mcu_clx2);
    end
  endtask

  // ---------------------------------------------------------- vectors
  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;   // bit0 = start bit, bit9 = stop bit
  } tx_vec_t;

  typedef struct {
    logic [7:0] data;
    logic       stopv;
    logic [8:0] exp;     // {ferr, rx_data}
  } rx_vec_t;

  tx_vec_t tx_tab[3];
  rx_vec_t rx_tab[4];
  logic [9:0] burst_frames[5];
  logic [7:0] burst_bytes[5];

  initial begin
    bit ok, ok5, bad;
    logic acc_rxd;
    int n, lat;

    tx_tab[0] = '{8'hA5, 10'b1101001010};
    tx_tab[1] = '{8'h01, 10'b1000000010};
    tx_tab[2] = '{8'hFE, 10'b1111111100};

    rx_tab[0] = '{8'h3C, 1'b1, 9'h03C};
    rx_tab[1] = '{8'h55, 1'b0, 9'h155};
    rx_tab[2] = '{8'h00, 1'b1, 9'h000};
    rx_tab[3] = '{8'hFF, 1'b1, 9'h0FF};

    burst_bytes[0] = 8'h11; burst_frames[0] = 10'b1000100010;
    burst_bytes[1] = 8'h22; burst_frames[1] = 10'b1001000100;
    burst_bytes[2] = 8'h33; burst_frames[2] = 10'b1001100110;
    burst_bytes[3] = 8'h44; burst_frames[3] = 10'b1010001000;
    burst_bytes[4] = 8'h55; burst_frames[4] = 10'b1010101010;

    // ---------------- reset state
    mcu_rst_n   = 1'b0;
    clken       = 1'b1;
    tx_data     = 8'h00;
    tx_valid    = 1'b0;
    sci_txd_drv = 1'b1;
    loop_en     = 1'b0;
    repeat (3) @(negedge mcu_clx2);
    chk("rst_sci_rxd", sci_rxd, 1);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_tx_busy", tx_busy, 0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_ferr", rx_ferr, 0);
    mcu_rst_n = 1'b1;
    repeat (2) @(negedge mcu_clx2);

    // ---------------- single TX frames
    for (int v = 0; v < 3; v++) begin
      push_byte(tx_tab[v].data);
      wait_fall(ok);
      chk("tx_start_seen", ok, 1);
      if (ok) begin
        check_frame(tx_tab[v].frame, $sformatf("tx%0d", v));
        chk("tx_busy_in_stop", tx_busy, 1);
        @(negedge mcu_clx2);
        chk("tx_busy_after_160", tx_busy, 0);
        chk("tx_line_idle", sci_rxd, 1);
      end
      repeat (5) @(negedge mcu_clx2);
    end

    // ---------------- FIFO full, back-to-back frames
    clken = 1'b0;
    for (int i = 0; i < 4; i++) push_byte(burst_bytes[i]);
    chk("full_tx_ready", tx_ready, 0);
    chk("full_tx_busy", tx_busy, 1);
    chk("full_line_idle", sci_rxd, 1);
    tx_data  = burst_bytes[4];
    tx_valid = 1'b1;
    repeat (3) @(negedge mcu_clx2);
    chk("full_refuse_ready", tx_ready, 0);
    clken = 1'b1;
    ok5 = 0;
    acc_rxd = 1'b1;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          if (tx_ready) begin
            ok5 = 1;
            acc_rxd = sci_rxd;
            break;
          end
          @(negedge mcu_clx2);
        end
        @(negedge mcu_clx2);
        tx_valid = 1'b0;
      end
      begin
        wait_fall(ok);
        chk("burst_start_seen", ok, 1);
        if (ok) begin
          for (int f = 0; f < 5; f++) begin
            if (f > 0) @(negedge mcu_clx2);
            check_frame(burst_frames[f], $sformatf("burst%0d", f));
          end
          @(negedge mcu_clx2);
          chk("burst_busy_after_800", tx_busy, 0);
        end
      end
    join
    chk("push5_accepted", ok5, 1);
    chk("push5_after_pop", acc_rxd, 0);
    repeat (5) @(negedge mcu_clx2);

    // ---------------- RX frames
    for (int v = 0; v < 4; v++) begin
      got_q.delete();
      exp_q.push_back(rx_tab[v].exp);
      send_rx(rx_tab[v].data, rx_tab[v].stopv);
      sci_txd_drv = 1'b1;
      repeat (20) @(negedge mcu_clx2);
      if (got_q.size() > 0) begin
        lat = got_cyc - t0;
        chk($sformatf("rx%0d_latency_ok(%0d)", v, lat), (lat >= 150 && lat <= 158), 1);
      end
      chk("rx_data_held", rx_data, rx_tab[v].exp[7:0]);
      chk("rx_valid_pulse_done", rx_valid, 0);
      check_rx($sformatf("rx%0d", v));
    end

    // ---------------- start glitch
    @(negedge mcu_clx2);
    sci_txd_drv = 1'b0;
    repeat (4) @(negedge mcu_clx2);
    sci_txd_drv = 1'b1;
    repeat (200) @(negedge mcu_clx2);
    check_rx("glitch");

    // ---------------- framing error, line stays low, then recovery
    exp_q.push_back(9'h155);
    send_rx(8'h55, 1'b0);
    repeat (400) @(negedge mcu_clx2);
    chk("ferr_line_low_rx_data", rx_data, 8'h55);
    check_rx("ferr_hold_low");
    sci_txd_drv = 1'b1;
    repeat (20) @(negedge mcu_clx2);
    exp_q.push_back(9'h0C3);
    send_rx(8'hC3, 1'b1);
    sci_txd_drv = 1'b1;
    repeat (20) @(negedge mcu_clx2);
    check_rx("ferr_recover");

    // ---------------- clken every 3rd cycle, loopback
    loop_en = 1'b1;
    got_q.delete();
    exp_q.push_back(9'h081);
    fork
      begin
        for (int k = 0; k < 800; k++) begin
          clken = (k % 3 == 0);
          @(negedge mcu_clx2);
        end
        clken = 1'b1;
      end
      begin
        push_byte(8'h81);
        wait_fall(ok);
        chk("slow_start_seen", ok, 1);
        n = 0;
        while (tx_busy && n < 700) begin
          @(negedge mcu_clx2);
          n++;
        end
        chk("slow_frame_cycles", n, 480);
      end
    join
    repeat (5) @(negedge mcu_clx2);
    check_rx("loopback");
    loop_en = 1'b0;
    repeat (5) @(negedge mcu_clx2);

    // ---------------- reset mid-frame with bytes queued
    clken = 1'b0;
    push_byte(8'h00);
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    clken = 1'b1;
    wait_fall(ok);
    chk("rst_test_start_seen", ok, 1);
    repeat (40) @(negedge mcu_clx2);
    chk("pre_reset_line", sci_rxd, 0);
    chk("pre_reset_busy", tx_busy, 1);
    #2;
    mcu_rst_n = 1'b0;
    #1;
    chk("midrst_sci_rxd", sci_rxd, 1);
    chk("midrst_tx_ready", tx_ready, 1);
    chk("midrst_tx_busy", tx_busy, 0);
    repeat (2) @(negedge mcu_clx2);
    mcu_rst_n = 1'b1;
    bad = 0;
    repeat (400) begin
      @(negedge mcu_clx2);
      if (sci_rxd !== 1'b1 || tx_busy !== 1'b0) bad = 1;
    end
    chk("post_reset_quiet", bad, 0);
    check_rx("post_reset_rx");

    chk("stray_ferr", stray_ferr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
